// File: rtl/sdp_rdma_gather_pkg.sv
// Shared constants, state encoding and mask helpers for the SDP RDMA beat gather block.
package sdp_rdma_gather_pkg;

   localparam int AW       = 128;
   localparam int IW       = 512;
   localparam int SW       = 13;
   localparam int NA       = IW / AW;
   localparam int FW       = $clog2(NA) + 1;
   localparam int EOL_BIT  = SW;
   localparam int SIZE_LSB = 0;
   localparam int MASK_LSB = 2 * AW;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATHER = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   // Illegal masks carry no atoms; a second atom beyond the command's end is dropped.
   function automatic logic [1:0] eff_mask(input logic [1:0] mask, input logic two_ok);
      logic [1:0] m;
      case (mask)
         2'b01:   m = 2'b01;
         2'b11:   m = two_ok ? 2'b11 : 2'b01;
         default: m = 2'b00;
      endcase
      return m;
   endfunction

   function automatic logic [1:0] atom_cnt(input logic [1:0] m);
      return {1'b0, m[0]} + {1'b0, m[1]};
   endfunction

endpackage

// File: rtl/sdp_rdma_gather_chk.sv
// Protocol checks on accepted response beats.
module sdp_rdma_gather_chk
   import sdp_rdma_gather_pkg::*;
(
   input logic        i_clk,
   input logic        i_rst_n,
   input logic        i_beat_fire,
   input logic [1:0]  i_mask,
   input logic [SW:0] i_rem
);

   a_mask_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_beat_fire |-> ((i_mask == 2'b01) || (i_mask == 2'b11)));

   a_no_excess_atom: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_beat_fire && (i_mask == 2'b11)) |-> (i_rem > (SW + 1)'(1)));

endmodule

// File: rtl/sdp_rdma_gather_slot_wr.sv
// Decodes fill level and effective beat mask into slot write enables and atom selects.
module sdp_rdma_gather_slot_wr
   import sdp_rdma_gather_pkg::*;
(
   input  logic [FW-1:0] i_fill,
   input  logic [1:0]    i_mask,
   output logic [NA-1:0] o_slot_we,
   output logic [NA-1:0] o_slot_sel,
   output logic          o_res_ld
);

   // atom0 lands at slot fill, atom1 at fill+1; a select bit of 1 picks atom1
   always_comb begin
      o_slot_we  = {NA{1'b0}};
      o_slot_sel = {NA{1'b0}};
      for (int k = 0; k < NA; k++) begin
         o_slot_we[k]  = (i_mask[0] && (FW'(k) == i_fill)) ||
                         (i_mask[1] && (FW'(k) == (i_fill + FW'(1))));
         o_slot_sel[k] = i_mask[1] && (FW'(k) == (i_fill + FW'(1)));
      end
      o_res_ld = i_mask[1] && (i_fill == FW'(NA - 1));
   end

endmodule

// File: rtl/sdp_rdma_beat_gather.sv
// Gathers 1-2 atom DMA response beats into IW-bit words tagged with end-of-line,
// under control of a per-transfer atom-count command stream.
module sdp_rdma_beat_gather
   import sdp_rdma_gather_pkg::*;
(
   input  logic            nvdla_core_clk,
   input  logic            nvdla_core_rstn,
   input  logic            cmd_pvld,
   output logic            cmd_prdy,
   input  logic [SW:0]     cmd_pd,
   input  logic            dma_rsp_pvld,
   output logic            dma_rsp_prdy,
   input  logic [2*AW+1:0] dma_rsp_pd,
   output logic            out_pvld,
   input  logic            out_prdy,
   output logic [IW:0]     out_data,
   output logic            idle
);

   state_t         r_state;
   logic [SW:0]    r_rem;
   logic [FW-1:0]  r_fill;
   logic           r_eol;
   logic           r_res_v;
   logic [AW-1:0]  r_res;
   logic [AW-1:0]  r_slot [NA];
   logic           r_out_vld;
   logic [IW:0]    r_out_data;

   logic [AW-1:0]  w_atom0;
   logic [AW-1:0]  w_atom1;
   logic [1:0]     w_mask;
   logic [1:0]     w_cnt;
   logic [SW:0]    w_rem_nxt;
   logic [FW-1:0]  w_fill_sum;
   logic           w_out_free;
   logic           w_cmd_fire;
   logic           w_beat_fire;
   logic           w_done;
   logic           w_word_cmpl;
   logic           w_ovf;
   logic           w_eol_bit;
   logic           w_load_gather;
   logic           w_load_flush;
   logic [NA-1:0]  w_slot_we;
   logic [NA-1:0]  w_slot_sel;
   logic           w_res_ld;
   logic [IW-1:0]  w_word;

   assign w_atom0     = dma_rsp_pd[0 +: AW];
   assign w_atom1     = dma_rsp_pd[AW +: AW];
   assign w_mask      = eff_mask(dma_rsp_pd[MASK_LSB +: 2], r_rem > (SW + 1)'(1));
   assign w_cnt       = atom_cnt(w_mask);
   assign w_rem_nxt   = r_rem - (SW + 1)'(w_cnt);
   assign w_fill_sum  = r_fill + FW'(w_cnt);

   assign w_out_free  = !r_out_vld || out_prdy;
   assign cmd_prdy    = (r_state == ST_IDLE);
   assign dma_rsp_prdy = (r_state == ST_GATHER) && w_out_free;
   assign w_cmd_fire  = cmd_pvld && cmd_prdy;
   assign w_beat_fire = dma_rsp_pvld && dma_rsp_prdy;

   assign w_done      = (w_rem_nxt == (SW + 1)'(0));
   assign w_word_cmpl = (w_fill_sum >= FW'(NA)) || w_done;
   assign w_ovf       = w_res_ld;
   assign w_eol_bit   = r_eol && w_done && !w_ovf;

   assign w_load_gather = w_beat_fire && w_word_cmpl;
   assign w_load_flush  = (r_state == ST_FLUSH) && w_out_free;

   assign out_pvld = r_out_vld;
   assign out_data = r_out_data;
   assign idle     = (r_state == ST_IDLE) && !r_out_vld;

   sdp_rdma_gather_slot_wr u_slot_wr (
      .i_fill     (r_fill),
      .i_mask     (w_mask),
      .o_slot_we  (w_slot_we),
      .o_slot_sel (w_slot_sel),
      .o_res_ld   (w_res_ld)
   );

   sdp_rdma_gather_chk u_chk (
      .i_clk       (nvdla_core_clk),
      .i_rst_n     (nvdla_core_rstn),
      .i_beat_fire (w_beat_fire),
      .i_mask      (dma_rsp_pd[MASK_LSB +: 2]),
      .i_rem       (r_rem)
   );

   // Outgoing word: held slots merged with the current beat, slots at or past the new fill zeroed
   always_comb begin
      w_word = {IW{1'b0}};
      for (int k = 0; k < NA; k++) begin
         if (FW'(k) >= w_fill_sum) begin
            w_word[k*AW +: AW] = {AW{1'b0}};
         end else if (w_slot_we[k]) begin
            w_word[k*AW +: AW] = w_slot_sel[k] ? w_atom1 : w_atom0;
         end else begin
            w_word[k*AW +: AW] = r_slot[k];
         end
      end
   end

   // Transfer FSM with atom countdown, fill level and residue flag
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_state <= ST_IDLE;
         r_rem   <= {(SW + 1){1'b0}};
         r_fill  <= {FW{1'b0}};
         r_eol   <= 1'b0;
         r_res_v <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_fire) begin
                  r_rem   <= {1'b0, cmd_pd[SIZE_LSB +: SW]} + (SW + 1)'(1);
                  r_eol   <= cmd_pd[EOL_BIT];
                  r_fill  <= {FW{1'b0}};
                  r_res_v <= 1'b0;
                  r_state <= ST_GATHER;
               end
            end
            ST_GATHER: begin
               if (w_beat_fire) begin
                  r_rem   <= w_rem_nxt;
                  // residue of an overflowing beat already sits in slot 0 for the next word
                  r_res_v <= w_ovf;
                  if (w_word_cmpl) begin
                     r_fill <= w_ovf ? FW'(1) : FW'(0);
                  end else begin
                     r_fill <= w_fill_sum;
                  end
                  if (w_done) begin
                     r_state <= w_ovf ? ST_FLUSH : ST_IDLE;
                  end
               end
            end
            ST_FLUSH: begin
               if (w_out_free) begin
                  r_res_v <= 1'b0;
                  r_fill  <= {FW{1'b0}};
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Slot array and residue data, not reset
   always_ff @(posedge nvdla_core_clk) begin
      if (w_beat_fire) begin
         for (int k = 0; k < NA; k++) begin
            if (w_slot_we[k]) begin
               r_slot[k] <= w_slot_sel[k] ? w_atom1 : w_atom0;
            end
         end
         if (w_ovf) begin
            r_slot[0] <= w_atom1;
            r_res     <= w_atom1;
         end
      end
   end

   // Output valid holds until the downstream takes the word
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_out_vld <= 1'b0;
      end else if (w_load_gather || w_load_flush) begin
         r_out_vld <= 1'b1;
      end else if (out_prdy) begin
         r_out_vld <= 1'b0;
      end
   end

   // Output data register, loaded only when the output slot is free
   always_ff @(posedge nvdla_core_clk) begin
      if (w_load_gather) begin
         r_out_data <= {w_eol_bit, w_word};
      end else if (w_load_flush) begin
         r_out_data <= {r_eol, {(IW - AW){1'b0}}, r_res};
      end
   end

endmodule
